// File: rtl/speed_governor.sv
// Cruise-control speed governor: tracks vehicle speed and a cruise setpoint across IDLE/CRUISE/ACCEL/DECEL.
// One-cycle latency, all outputs registered; no backpressure (inputs sampled every rising edge).
module speed_governor #(
  parameter logic [7:0] STEP       = 8'd5,
  parameter logic [7:0] MAX_SPEED  = 8'd200,
  parameter logic [7:0] MIN_CRUISE = 8'd40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       throttle,
  input  logic       brake,
  input  logic       set,
  input  logic       accel,
  input  logic       coast,
  input  logic       cancel,
  output logic [7:0] speed,
  output logic [7:0] cruise_speed,
  output logic       cruise_on,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CRUISE = 2'b01,
    S_ACCEL  = 2'b10,
    S_DECEL  = 2'b11
  } state_t;

  state_t     r_state;
  logic [7:0] r_speed;
  logic [7:0] r_cruise;
  logic       r_cruise_on;

  logic [8:0] w_inc_sum;
  logic [7:0] w_inc;
  logic [8:0] w_dec_diff;
  logic [7:0] w_dec;
  logic [9:0] w_brk_diff;
  logic [7:0] w_brk;
  logic [7:0] w_idle_spd;
  logic [7:0] w_toward;
  logic       w_dec_low;
  logic       w_set_ok;

  // Arithmetic is widened so that saturation is decided on the true result, never a wrapped one.
  assign w_inc_sum  = {1'b0, r_speed} + {1'b0, STEP};
  assign w_inc      = (w_inc_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : w_inc_sum[7:0];
  assign w_dec_diff = {1'b0, r_speed} - {1'b0, STEP};
  assign w_dec      = w_dec_diff[8] ? 8'd0 : w_dec_diff[7:0];
  assign w_brk_diff = {2'b00, r_speed} - {1'b0, STEP, 1'b0};
  assign w_brk      = w_brk_diff[9] ? 8'd0 : w_brk_diff[7:0];

  assign w_idle_spd = throttle ? w_inc : w_dec;
  assign w_dec_low  = (w_dec < MIN_CRUISE);
  assign w_set_ok   = set && ((r_state != S_IDLE) || (r_speed >= MIN_CRUISE));

  always_comb begin
    w_toward = r_speed;
    if (r_speed < r_cruise) begin
      w_toward = (w_inc > r_cruise) ? r_cruise : w_inc;
    end else if (r_speed > r_cruise) begin
      w_toward = (w_dec < r_cruise) ? r_cruise : w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_speed     <= 8'd0;
      r_cruise    <= 8'd0;
      r_cruise_on <= 1'b0;
    end else if (brake) begin
      r_state     <= S_IDLE;
      r_speed     <= w_brk;
      r_cruise_on <= 1'b0;
    end else if (cancel) begin
      r_state     <= S_IDLE;
      r_speed     <= w_idle_spd;
      r_cruise_on <= 1'b0;
    end else if (w_set_ok) begin
      // Engage from IDLE or re-latch while engaged; speed is held this cycle.
      r_state     <= S_CRUISE;
      r_cruise    <= r_speed;
      r_cruise_on <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_speed <= w_idle_spd;
        end
        S_CRUISE: begin
          if (accel) begin
            r_state <= S_ACCEL;
            r_speed <= w_inc;
          end else if (coast) begin
            r_speed     <= w_dec;
            r_state     <= w_dec_low ? S_IDLE : S_DECEL;
            r_cruise_on <= !w_dec_low;
          end else if (throttle) begin
            r_speed <= w_inc;
          end else begin
            r_speed <= w_toward;
          end
        end
        S_ACCEL: begin
          if (accel) begin
            r_speed <= w_inc;
          end else begin
            r_state  <= S_CRUISE;
            r_cruise <= r_speed;
          end
        end
        S_DECEL: begin
          if (accel) begin
            r_state <= S_ACCEL;
            r_speed <= w_inc;
          end else if (coast) begin
            // Dropping under the engage floor disengages; setpoint is kept for reference.
            r_speed     <= w_dec;
            r_state     <= w_dec_low ? S_IDLE : S_DECEL;
            r_cruise_on <= !w_dec_low;
          end else begin
            r_state  <= S_CRUISE;
            r_cruise <= r_speed;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cruise_on <= 1'b0;
        end
      endcase
    end
  end

  assign speed        = r_speed;
  assign cruise_speed = r_cruise;
  assign cruise_on    = r_cruise_on;
  assign state        = r_state;

endmodule

// File: tb/tb_speed_governor.sv
// Bench for speed_governor: directed scenarios with literal expectations, then random stimulus
// against a behavioural model; a monitor pops expected outputs from a scoreboard queue each cycle.
module tb_speed_governor;

  localparam int STEP = 5;
  localparam int MAXS = 200;
  localparam int MINC = 40;

  localparam int ST_I = 0;
  localparam int ST_C = 1;
  localparam int ST_A = 2;
  localparam int ST_D = 3;

  // Input vector: {reset, throttle, brake, set, accel, coast, cancel}
  localparam logic [6:0] R = 7'b1000000;
  localparam logic [6:0] T = 7'b0100000;
  localparam logic [6:0] B = 7'b0010000;
  localparam logic [6:0] S = 7'b0001000;
  localparam logic [6:0] A = 7'b0000100;
  localparam logic [6:0] C = 7'b0000010;
  localparam logic [6:0] X = 7'b0000001;
  localparam logic [6:0] N = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       throttle = 1'b0;
  logic       brake = 1'b0;
  logic       set = 1'b0;
  logic       accel = 1'b0;
  logic       coast = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] speed;
  logic [7:0] cruise_speed;
  logic       cruise_on;
  logic [1:0] state;

  speed_governor dut (
    .clk         (clk),
    .reset       (reset),
    .throttle    (throttle),
    .brake       (brake),
    .set         (set),
    .accel       (accel),
    .coast       (coast),
    .cancel      (cancel),
    .speed       (speed),
    .cruise_speed(cruise_speed),
    .cruise_on   (cruise_on),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    spd;
    int    cs;
    int    st;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: plain integers, rules applied directly from the behaviour description.
  int m_spd = 0;
  int m_cs  = 0;
  int m_st  = ST_I;

  function automatic int up(int v);
    return (v + STEP > MAXS) ? MAXS : v + STEP;
  endfunction

  function automatic int down(int v, int d);
    return (v < d) ? 0 : v - d;
  endfunction

  task automatic model_step(input logic [6:0] v);
    logic r, t, b, s, a, c, x;
    int ns, nc, nst;
    {r, t, b, s, a, c, x} = v;
    ns = m_spd; nc = m_cs; nst = m_st;
    if (r) begin
      ns = 0; nc = 0; nst = ST_I;
    end else if (b) begin
      ns = down(m_spd, 2 * STEP); nst = ST_I;
    end else if (x) begin
      ns = t ? up(m_spd) : down(m_spd, STEP); nst = ST_I;
    end else if (s && (m_st != ST_I || m_spd >= MINC)) begin
      nc = m_spd; nst = ST_C;
    end else if (m_st == ST_I) begin
      ns = t ? up(m_spd) : down(m_spd, STEP);
    end else if (a) begin
      if (m_st == ST_A || m_st == ST_C || m_st == ST_D) begin
        ns = up(m_spd); nst = ST_A;
      end
    end else if (m_st == ST_A) begin
      nc = m_spd; nst = ST_C;
    end else if (c) begin
      ns = down(m_spd, STEP);
      nst = (ns < MINC) ? ST_I : ST_D;
    end else if (m_st == ST_D) begin
      nc = m_spd; nst = ST_C;
    end else if (t) begin
      ns = up(m_spd);
    end else if (m_spd < m_cs) begin
      ns = (up(m_spd) > m_cs) ? m_cs : up(m_spd);
    end else if (m_spd > m_cs) begin
      ns = (down(m_spd, STEP) < m_cs) ? m_cs : down(m_spd, STEP);
    end
    m_spd = ns; m_cs = nc; m_st = nst;
  endtask

  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {reset, throttle, brake, set, accel, coast, cancel} = v;
    model_step(v);
  endtask

  task automatic dstep(input logic [6:0] v, input int es, input int ec, input int est, input string nm);
    exp_t e;
    drive(v);
    e.spd = es; e.cs = ec; e.st = est; e.name = nm;
    q.push_back(e);
  endtask

  task automatic rstep(input logic [6:0] v);
    exp_t e;
    drive(v);
    e.spd = m_spd; e.cs = m_cs; e.st = m_st; e.name = "random";
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (speed !== e.spd[7:0] || cruise_speed !== e.cs[7:0] ||
            state !== e.st[1:0] || cruise_on !== (e.st != ST_I)) begin
          n_fail++;
          $display("FAIL %s: got speed=%0d cruise_speed=%0d state=%0d cruise_on=%0b, expected speed=%0d cruise_speed=%0d state=%0d cruise_on=%0b",
                   e.name, speed, cruise_speed, state, cruise_on, e.spd, e.cs, e.st, (e.st != ST_I));
        end
      end
    end
  end

  initial begin
    logic [6:0] v;
    int wait_cyc;

    dstep(R, 0, 0, ST_I, "reset0");
    dstep(R, 0, 0, ST_I, "reset1");
    for (int k = 1; k <= 10; k++) dstep(T, 5 * k, 0, ST_I, "throttle_ramp");
    dstep(N, 45, 0, ST_I, "idle_coast");
    dstep(T, 50, 0, ST_I, "throttle_50");
    dstep(S, 50, 50, ST_C, "set_50");
    dstep(T, 55, 50, ST_C, "override_55");
    dstep(T, 60, 50, ST_C, "override_60");
    dstep(N, 55, 50, ST_C, "return_55");
    dstep(N, 50, 50, ST_C, "return_50");
    dstep(N, 50, 50, ST_C, "hold_50");
    for (int k = 1; k <= 4; k++) dstep(A, 50 + 5 * k, 50, ST_A, "accel_ramp");
    dstep(N, 70, 70, ST_C, "accel_release");
    for (int k = 1; k <= 6; k++) dstep(C, 70 - 5 * k, 70, ST_D, "decel_ramp");
    dstep(C, 35, 70, ST_I, "decel_below_min");
    for (int k = 1; k <= 5; k++) dstep(T, 35 + 5 * k, 70, ST_I, "throttle_60");
    dstep(S, 60, 60, ST_C, "set_60");
    dstep(B | A, 50, 60, ST_I, "brake_beats_accel");
    for (int k = 1; k <= 4; k++) dstep(N, 50 - 5 * k, 60, ST_I, "coast_30");
    dstep(S, 25, 60, ST_I, "set_below_min");
    for (int k = 1; k <= 37; k++) dstep(T, (25 + 5 * k > 200) ? 200 : 25 + 5 * k, 60, ST_I, "saturate");
    for (int k = 1; k <= 19; k++) dstep(B, 200 - 10 * k, 60, ST_I, "brake_ramp");
    dstep(N, 5, 60, ST_I, "coast_5");
    dstep(B, 0, 60, ST_I, "brake_no_wrap");
    dstep(B, 0, 60, ST_I, "brake_at_zero");
    dstep(N, 0, 60, ST_I, "coast_at_zero");
    for (int k = 1; k <= 15; k++) dstep(T, 5 * k, 60, ST_I, "throttle_75");
    dstep(S, 75, 75, ST_C, "set_75");
    dstep(A, 80, 75, ST_A, "accel_80");
    dstep(R | A, 0, 0, ST_I, "reset_mid_accel");
    dstep(T, 5, 0, ST_I, "after_reset");
    for (int k = 2; k <= 10; k++) dstep(T, 5 * k, 0, ST_I, "throttle_again");
    dstep(S, 50, 50, ST_C, "set_again");
    dstep(X | T, 55, 50, ST_I, "cancel_throttle");

    for (int i = 0; i < 600; i++) begin
      v = N;
      v[6] = ($urandom_range(0, 199) == 0);
      v[5] = ($urandom_range(0, 99) < 55);
      v[4] = ($urandom_range(0, 99) < 4);
      v[3] = ($urandom_range(0, 99) < 10);
      v[2] = ($urandom_range(0, 99) < 20);
      v[1] = ($urandom_range(0, 99) < 25);
      v[0] = ($urandom_range(0, 99) < 4);
      rstep(v);
    end

    @(negedge clk);
    {reset, throttle, brake, set, accel, coast, cancel} = N;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
